if_fetch_unit: RTL and testbench
================================

# if_fetch_unit

Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the IF/ID pipeline register. It owns the fetch PC, issues word reads to a variable-latency instruction memory with in-order responses, and buffers returned words in a small FIFO. It presents one instruction per cycle, plus PC+4, to IF/ID. It honours freeze from the hazard unit and redirects on taken branches, discarding stale in-flight responses.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- DEPTH, 4, prefetch buffer entries; also the maximum of outstanding requests plus buffered words (power of 2, ≥2)

- clk  in  1  clock, rising edge
- rst_b  in  1  asynchronous, active-low reset
- freeze  in  1  hazard stall; holds the head instruction
- branch_taken  in  1  redirect fetch this cycle
- branch_target  in  32  new fetch address (word aligned)
- imem_req  out  1  read request valid
- imem_addr  out  32  read address = fetch_pc
- imem_ready  in  1  memory accepts the request this cycle
- imem_rvalid  in  1  read data valid, in request order
- imem_rdata  in  32  instruction word
- inst_out  out  32  head instruction; 0 (NOP bubble) when none
- pc_out  out  32  head address + 4; 0 when no instruction

## Operation
- State:
  - fetch_pc (32 bits)
  - FIFO of DEPTH entries, each holding {addr, inst}
  - occ: 0..DEPTH
  - outstanding: 0..DEPTH
  - drop: 0..DEPTH, the count of in-flight responses to discard
- Reset (async, rst_b=0):
  - fetch_pc=RESET_PC; occ=outstanding=drop=0
  - imem_req=0, inst_out=0, pc_out=0
- Issue: imem_req = !branch_taken && (outstanding + occ < DEPTH), using registered counts.
  - Accept = imem_req && imem_ready → outstanding+1, fetch_pc += 4 (32-bit wrap from FFFF_FFFC to 0).
  - imem_addr = fetch_pc always.
- Response: on imem_rvalid, outstanding−1.
  - If drop>0: discard the word and decrement drop.
  - Otherwise: write {addr of that request, imem_rdata} at the tail; occ+1.
  - The address for each entry comes from a per-request address record, or from a second counter trailing fetch_pc by (outstanding+occ) words. Either implementation is acceptable.
- Present: occ>0 → inst_out = head inst, pc_out = head addr + 4; else both 0.
- Pop: occ>0 && !freeze && !branch_taken → head advances; occ−1.
- Redirect (branch_taken=1, priority over freeze):
  - inst_out and pc_out forced to 0 that cycle.
  - No request that cycle.
  - Next edge: fetch_pc=branch_target, FIFO cleared (occ=0), drop = outstanding after this cycle's response.
  - A response arriving in the redirect cycle is discarded regardless of drop.
- Simultaneous push+pop: occ unchanged. Issue+response same cycle: outstanding unchanged.
- The credit rule guarantees the FIFO never overflows. Behaviour with imem_rvalid while outstanding=0 is undefined; flag it with an assertion.

## Timing
- Accept at cycle t, rvalid at t+L → instruction on inst_out at t+L+1 (no bypass).
- 1-cycle memory, ready=1, freeze=0: one instruction per cycle in steady state.
  - First instruction appears at cycle 2 after reset release.
- Branch asserted in cycle b → first request to branch_target at b+1.
  - Its instruction reaches inst_out at b+2+L at the earliest.
- Freeze: outputs stable while asserted. Issue continues until outstanding+occ = DEPTH.
- Outputs are combinational from registered state and branch_taken only. No path from imem_rdata to inst_out.
- Reset mid-operation: all counters clear immediately. Responses to pre-reset requests are the memory's responsibility (memory is reset together with the fetch unit).

## Test plan
- Reset then 1-cycle memory, mem[i]=0x2000_0000+i:
  - imem_addr sequence 0,4,8,… one per cycle.
  - inst_out 0x2000_0000 with pc_out 4 at cycle 2, then 0x2000_0001/8, …
- Freeze held 3 cycles while head = word at 0x10:
  - inst_out/pc_out stable at mem[4]/0x14.
  - imem_req drops once outstanding+occ=4.
  - After release, no word is lost or duplicated.
- 3-cycle memory latency, 2 requests in flight; branch_taken with target 0x400:
  - Both old responses discarded (drop 2→0).
  - Next inst_out is mem[0x100] with pc_out 0x404.
- Branch coinciding with freeze and an arriving response:
  - Outputs 0 that cycle; response dropped.
  - Fetch resumes at target the next cycle.
- imem_ready toggled 1,0,1,0:
  - Addresses advance only on accepted cycles.
  - Output stream stays in order with 0 bubbles where the FIFO is empty.
- RESET_PC=32'hFFFF_FFF8: fetches FFFF_FFF8, FFFF_FFFC, 0000_0000; pc_out for the last is 4.

Source files
------------

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory read bus between the fetch unit and the instruction memory.
//   imem_req    fetch unit requests a word read this cycle
//   imem_addr   word address of the read
//   imem_ready  memory accepts the request this cycle
//   imem_rvalid read data valid; responses return in request order
//   imem_rdata  returned instruction word
// master: fetch-unit side; slave: memory side.
interface if_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage of the 5-stage MIPS pipeline, feeding the IF/ID register.
// Owns the fetch PC, issues word reads to a variable-latency in-order instruction
// memory, buffers returned words in a DEPTH-entry prefetch FIFO and presents one
// instruction (plus its address + 4) per cycle. Honours freeze and branch redirects;
// responses still in flight at a redirect are discarded.
//   clk           clock, rising edge
//   rst_b         asynchronous active-low reset
//   freeze        hazard stall, holds the head instruction
//   branch_taken  redirect fetch to branch_target this cycle
//   branch_target new fetch address (word aligned)
//   imem          instruction-memory read bus (master side)
//   inst_out      head instruction, 0 when the buffer is empty or on redirect
//   pc_out        head address + 4, 0 when no instruction is presented
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  freeze,
  input  logic                  branch_taken,
  input  logic [31:0]           branch_target,
  if_fetch_unit_if.master       imem,
  output logic [31:0]           inst_out,
  output logic [31:0]           pc_out
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_SUM = DEPTH[CNT_W:0];

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  // Address of the next response to be buffered; trails fetch_pc by the
  // number of requests still in flight (dropped responses never advance it).
  logic [31:0]      resp_pc_q, resp_pc_d;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic [CNT_W-1:0] outst_q, outst_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic [31:0] addr_mem [DEPTH];
  logic [31:0] inst_mem [DEPTH];

  logic [CNT_W:0] credit_used;
  logic           accept, resp, push, pop, discard;

  // Credit rule: in-flight plus buffered words never exceed DEPTH, so a
  // response always finds a free FIFO slot.
  assign credit_used   = {1'b0, outst_q} + {1'b0, occ_q};
  assign imem.imem_req  = rst_b && !branch_taken && (credit_used < DEPTH_SUM);
  assign imem.imem_addr = fetch_pc_q;

  assign accept  = imem.imem_req && imem.imem_ready;
  assign resp    = imem.imem_rvalid;
  assign push    = resp && !branch_taken && (drop_q == '0);
  assign discard = resp && !branch_taken && (drop_q != '0);
  assign pop     = (occ_q != '0) && !freeze && !branch_taken;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    occ_d      = occ_q;
    outst_d    = outst_q + CNT_W'(accept) - CNT_W'(resp);
    drop_d     = drop_q;
    if (branch_taken) begin
      // No request is issued this cycle, so only the response can change
      // the in-flight count; everything left in flight is stale.
      fetch_pc_d = branch_target;
      resp_pc_d  = branch_target;
      head_d     = '0;
      tail_d     = '0;
      occ_d      = '0;
      drop_d     = outst_q - CNT_W'(resp);
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
      if (push) begin
        resp_pc_d = resp_pc_q + 32'd4;
        tail_d    = tail_q + PTR_W'(1);
      end
      if (pop) head_d = head_q + PTR_W'(1);
      occ_d  = occ_q + CNT_W'(push) - CNT_W'(pop);
      drop_d = drop_q - CNT_W'(discard);
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      occ_q      <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  // Storage only; validity is tracked by occ/head/tail.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail_q] <= resp_pc_q;
      inst_mem[tail_q] <= imem.imem_rdata;
    end
  end

  always_comb begin
    inst_out = '0;
    pc_out   = '0;
    if ((occ_q != '0) && !branch_taken) begin
      inst_out = inst_mem[head_q];
      pc_out   = addr_mem[head_q] + 32'd4;
    end
  end

`ifndef SYNTHESIS
  rvalid_needs_request: assert property (
    @(posedge clk) disable iff (!rst_b) imem.imem_rvalid |-> (outst_q != '0)
  ) else $error("imem_rvalid with no outstanding request");
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] inst_out, pc_out, inst_out2, pc_out2;

  if_fetch_unit_if bus ();
  if_fetch_unit_if bus2 ();

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) u_dut (
    .clk           (clk),
    .rst_b         (rst_b),
    .freeze        (freeze),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem          (bus.master),
    .inst_out      (inst_out),
    .pc_out        (pc_out)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) u_dut_wrap (
    .clk           (clk),
    .rst_b         (rst_b),
    .freeze        (1'b0),
    .branch_taken  (1'b0),
    .branch_target (32'h0000_0000),
    .imem          (bus2.master),
    .inst_out      (inst_out2),
    .pc_out        (pc_out2)
  );

  function automatic logic [31:0] mw(input logic [31:0] a);
    return 32'h2000_0000 + (a >> 2);
  endfunction

  // Memory model: fixed latency, in order. Runs on the falling edge; the value
  // set in cycle j is what the DUT samples at the edge ending cycle j.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       q[$];
  int          cyc;
  int          lat;
  logic        pend2;
  logic [31:0] paddr2;

  always @(negedge clk) begin
    if (!rst_b) begin
      q.delete();
      cyc              = 0;
      bus.imem_rvalid  = 1'b0;
      bus.imem_rdata   = 32'h0;
      bus2.imem_rvalid = 1'b0;
      bus2.imem_rdata  = 32'h0;
      pend2            = 1'b0;
      paddr2           = 32'h0;
    end else begin
      if (q.size() > 0 && q[0].due == cyc) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mw(q[0].addr);
        void'(q.pop_front());
      end else begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'hDEAD_BEEF;
      end
      if (bus.imem_req && bus.imem_ready) q.push_back('{addr: bus.imem_addr, due: cyc + lat});
      cyc++;
      bus2.imem_rvalid = pend2;
      bus2.imem_rdata  = mw(paddr2);
      pend2            = bus2.imem_req && bus2.imem_ready;
      paddr2           = bus2.imem_addr;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  // Leaves the bench in cycle 0 (first cycle after reset release).
  task automatic do_reset(input int l);
    next_cycle();
    rst_b         = 1'b0;
    freeze        = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    bus.imem_ready  = 1'b1;
    bus2.imem_ready = 1'b1;
    lat           = l;
    #1;
    chk("reset req", {31'b0, bus.imem_req}, 32'h0);
    chk("reset addr", bus.imem_addr, 32'h0);
    chk("reset inst", inst_out, 32'h0);
    chk("reset pc", pc_out, 32'h0);
    chk("reset wrap addr", bus2.imem_addr, 32'hFFFF_FFF8);
    chk("reset wrap inst", inst_out2, 32'h0);
    next_cycle();
    next_cycle();
    rst_b = 1'b1;
  endtask

  typedef struct {
    logic        freeze;
    logic        req;
    logic [31:0] addr;
    logic [31:0] inst;
    logic [31:0] pc;
  } vec_t;

  vec_t tab[14];

  initial begin
    rst_b           = 1'b0;
    freeze          = 1'b0;
    branch_taken    = 1'b0;
    branch_target   = 32'h0;
    bus.imem_ready  = 1'b1;
    bus2.imem_ready = 1'b1;
    lat             = 1;

    // Streaming with 1-cycle memory, freeze held in cycles 6..8 (head at 0x10).
    for (int k = 0; k < 14; k++) begin
      tab[k].freeze = (k >= 6 && k <= 8);
      if (k <= 5) begin
        tab[k].req  = 1'b1;
        tab[k].addr = 32'(4 * k);
        tab[k].inst = (k >= 2) ? mw(32'(4 * (k - 2))) : 32'h0;
        tab[k].pc   = (k >= 2) ? 32'(4 * (k - 1)) : 32'h0;
      end else if (k <= 9) begin
        tab[k].req  = (k < 8);
        tab[k].addr = (k == 6) ? 32'h18 : (k == 7) ? 32'h1C : 32'h20;
        tab[k].inst = mw(32'h10);
        tab[k].pc   = 32'h14;
      end else begin
        tab[k].req  = 1'b1;
        tab[k].addr = 32'h20 + 32'(4 * (k - 10));
        tab[k].inst = mw(32'(4 * (k - 5)));
        tab[k].pc   = 32'(4 * (k - 4));
      end
    end

    do_reset(1);
    for (int k = 0; k < 14; k++) begin
      if (k > 0) next_cycle();
      freeze = tab[k].freeze;
      #1;
      chk($sformatf("stream req c%0d", k), {31'b0, bus.imem_req}, {31'b0, tab[k].req});
      chk($sformatf("stream addr c%0d", k), bus.imem_addr, tab[k].addr);
      chk($sformatf("stream inst c%0d", k), inst_out, tab[k].inst);
      chk($sformatf("stream pc c%0d", k), pc_out, tab[k].pc);
      case (k)
        0: chk("wrap addr c0", bus2.imem_addr, 32'hFFFF_FFF8);
        1: chk("wrap addr c1", bus2.imem_addr, 32'hFFFF_FFFC);
        2: begin
          chk("wrap addr c2", bus2.imem_addr, 32'h0000_0000);
          chk("wrap inst c2", inst_out2, mw(32'hFFFF_FFF8));
          chk("wrap pc c2", pc_out2, 32'hFFFF_FFFC);
        end
        3: chk("wrap pc c3", pc_out2, 32'h0000_0000);
        4: begin
          chk("wrap inst c4", inst_out2, mw(32'h0));
          chk("wrap pc c4", pc_out2, 32'h4);
        end
        default: ;
      endcase
    end
    freeze = 1'b0;

    // 3-cycle memory, branch with two requests in flight.
    do_reset(3);
    next_cycle();
    next_cycle();
    branch_taken  = 1'b1;
    branch_target = 32'h400;
    #1;
    chk("br req c2", {31'b0, bus.imem_req}, 32'h0);
    chk("br inst c2", inst_out, 32'h0);
    chk("br pc c2", pc_out, 32'h0);
    next_cycle();
    branch_taken = 1'b0;
    #1;
    chk("br addr c3", bus.imem_addr, 32'h400);
    chk("br req c3", {31'b0, bus.imem_req}, 32'h1);
    chk("br inst c3", inst_out, 32'h0);
    next_cycle();
    #1;
    chk("br addr c4", bus.imem_addr, 32'h404);
    chk("br inst c4", inst_out, 32'h0);
    next_cycle();
    #1;
    chk("br inst c5", inst_out, 32'h0);
    next_cycle();
    #1;
    chk("br inst c6", inst_out, 32'h0);
    next_cycle();
    #1;
    chk("br inst c7", inst_out, mw(32'h400));
    chk("br pc c7", pc_out, 32'h404);
    next_cycle();
    #1;
    chk("br inst c8", inst_out, mw(32'h404));
    chk("br pc c8", pc_out, 32'h408);

    // Branch together with freeze and an arriving response.
    do_reset(1);
    next_cycle();
    next_cycle();
    next_cycle();
    #1;
    chk("bf inst c3", inst_out, mw(32'h4));
    chk("bf pc c3", pc_out, 32'h8);
    next_cycle();
    freeze        = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 32'h800;
    #1;
    chk("bf rvalid c4", {31'b0, bus.imem_rvalid}, 32'h1);
    chk("bf inst c4", inst_out, 32'h0);
    chk("bf pc c4", pc_out, 32'h0);
    chk("bf req c4", {31'b0, bus.imem_req}, 32'h0);
    next_cycle();
    freeze       = 1'b0;
    branch_taken = 1'b0;
    #1;
    chk("bf addr c5", bus.imem_addr, 32'h800);
    chk("bf req c5", {31'b0, bus.imem_req}, 32'h1);
    chk("bf inst c5", inst_out, 32'h0);
    next_cycle();
    #1;
    chk("bf inst c6", inst_out, 32'h0);
    next_cycle();
    #1;
    chk("bf inst c7", inst_out, mw(32'h800));
    chk("bf pc c7", pc_out, 32'h804);

    // imem_ready alternating 1,0,1,0,...
    do_reset(1);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) next_cycle();
      bus.imem_ready = (k % 2 == 0);
      #1;
      if (k % 2 == 0) begin
        chk($sformatf("rdy addr c%0d", k), bus.imem_addr, 32'(4 * (k / 2)));
        chk($sformatf("rdy inst c%0d", k), inst_out,
            (k >= 2) ? mw(32'(4 * (k / 2 - 1))) : 32'h0);
        chk($sformatf("rdy pc c%0d", k), pc_out, (k >= 2) ? 32'(4 * (k / 2)) : 32'h0);
      end else begin
        chk($sformatf("rdy addr c%0d", k), bus.imem_addr, 32'(4 * ((k + 1) / 2)));
        chk($sformatf("rdy inst c%0d", k), inst_out, 32'h0);
      end
    end

    // Reset in the middle of activity clears everything at once.
    do_reset(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
